gcd_arbiter: RTL
================

Name: gcd_arbiter

Overview:
- Shares one GCD engine among NREQ requesters using round-robin arbitration.
- Captures a winner's operands and pulses the engine's start input. It then waits for the engine's done pulse, or a watchdog timeout.
- Returns the result on a shared response bus, tagged with the requester ID.
- Sits between client blocks and the single gcd engine instance. Only one operation is in flight at a time.

Parameters:
- NBITS, 32, operand/result width; must match the engine.
- NREQ, 4, number of requesters (2..16).
- IDW, 2, requester ID width; must be >= clog2(NREQ).
- TIMEOUT, 1024, maximum WAIT-state cycles before an error response (>= 4).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester request level.
- req_a  in  NREQ*NBITS  operand a; requester i uses bits [i*NBITS +: NBITS].
- req_b  in  NREQ*NBITS  operand b, same packing as req_a.
- req_ready  out  NREQ  one-cycle accept pulse to the granted requester.
- resp_valid  out  1  one-cycle response strobe.
- resp_id  out  IDW  requester the response belongs to.
- resp_result  out  NBITS  GCD result.
- resp_err  out  1  response is a timeout error; resp_result = 0.
- eng_a  out  NBITS  operand a to the engine.
- eng_b  out  NBITS  operand b to the engine.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_result  in  NBITS  engine result.
- eng_done  in  1  engine done pulse.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, last_grant = NREQ-1, watchdog counter = 0.
  - All outputs 0: req_ready, resp_valid, resp_id, resp_result, resp_err, eng_a, eng_b, eng_start, busy.
- All outputs are registered.
- States, in fixed order IDLE -> GRANT -> START -> WAIT -> RESP -> IDLE:
- IDLE:
  - If any req_valid is set, choose g = first set bit searching upward from last_grant+1 modulo NREQ.
  - Next edge: owner = g; eng_a/eng_b = req_a[g]/req_b[g]; req_ready[g] = 1; go to GRANT.
- GRANT:
  - req_ready returns to 0. Next edge: eng_start = 1, go to START.
  - eng_a/eng_b are held stable from GRANT until the response is issued.
- START:
  - eng_start returns to 0; counter = 0; go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - If eng_done is high: capture eng_result, set resp_err = 0, go to RESP.
  - Else, if counter == TIMEOUT-1: set resp_result = 0, resp_err = 1, go to RESP.
  - If eng_done arrives on the same cycle as the timeout, eng_done wins.
- RESP:
  - resp_valid = 1 for exactly one cycle, with resp_id = owner.
  - last_grant = owner; go to IDLE.
  - resp_result/resp_id/resp_err hold their values until the next response.
- Handshake rules:
  - A requester holds req_valid and operands until it sees its req_ready pulse, then deasserts req_valid.
  - A req_valid still high in the cycle after the req_ready pulse is treated as a new request.
  - req_valid is sampled only in IDLE. Changes in other states have no effect.
- Latency:
  - With the engine idle and exactly one request: req_ready 1 cycle after req_valid is sampled; eng_start 2 cycles after.
  - resp_valid is asserted 1 cycle after the eng_done cycle.
- Best-case request-to-response gap: 4 cycles plus engine time.
- eng_done seen outside WAIT is ignored.
- Operand b = 0 is forwarded unchanged; the engine result is passed through.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 other grants.
- Reset mid-operation: any state returns immediately to IDLE with outputs cleared. An in-flight engine operation is abandoned, and a subsequent stale eng_done is ignored.

Test Plan:
- Single request: req0 with a=48, b=18; model returns done with result 6 -> req_ready[0] pulse, one eng_start pulse with eng_a=48/eng_b=18, then resp_valid with id=0, result=6, err=0.
- Contention: all 4 requesters raise req_valid together, each re-raising after accept -> grant order 0,1,2,3,0. Each response id matches its grant; exactly one eng_start per grant.
- Timeout: TIMEOUT=8, engine never signals done -> resp_valid exactly 8 WAIT cycles after START, with err=1, result=0. The next request is granted normally.
- Done/timeout collision: eng_done on the cycle where counter=TIMEOUT-1, with result=5 -> err=0, result=5.
- Reset mid-WAIT: drop reset_n during WAIT -> all outputs 0 and busy=0 immediately. A late eng_done pulse produces no resp_valid.
- Stale done: eng_done pulsed while IDLE with no requests -> no resp_valid, state stays IDLE.

Source files
------------

// File: rtl/gcd_arbiter_if.sv
// Requester, response and engine signals of the shared GCD arbiter.
// slave: the arbiter itself; master: the clients/engine side.
interface gcd_arbiter_if #(
    parameter int unsigned NBITS = 32,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*NBITS-1:0] req_a;
    logic [NREQ*NBITS-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  resp_valid;
    logic [IDW-1:0]        resp_id;
    logic [NBITS-1:0]      resp_result;
    logic                  resp_err;
    logic [NBITS-1:0]      eng_a;
    logic [NBITS-1:0]      eng_b;
    logic                  eng_start;
    logic [NBITS-1:0]      eng_result;
    logic                  eng_done;
    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b, eng_result, eng_done,
        output req_ready, resp_valid, resp_id, resp_result, resp_err,
        output eng_a, eng_b, eng_start, busy
    );

    modport master (
        output req_valid, req_a, req_b, eng_result, eng_done,
        input  req_ready, resp_valid, resp_id, resp_result, resp_err,
        input  eng_a, eng_b, eng_start, busy
    );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one GCD engine among NREQ requesters.
// One operation in flight; a watchdog turns a silent engine into an error response.
module gcd_arbiter #(
    parameter int unsigned NBITS   = 32,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic          clk,
    input logic          reset_n,
    gcd_arbiter_if.slave bus
);
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {StIdle, StGrant, StStart, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [IDW-1:0]        last_grant_q, last_grant_d;
    logic [IDW-1:0]        owner_q, owner_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NREQ-1:0]       req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [IDW-1:0]        resp_id_q, resp_id_d;
    logic [NBITS-1:0]      resp_result_q, resp_result_d;
    logic                  resp_err_q, resp_err_d;
    logic [NBITS-1:0]      eng_a_q, eng_a_d;
    logic [NBITS-1:0]      eng_b_q, eng_b_d;
    logic                  eng_start_q, eng_start_d;
    logic                  busy_q, busy_d;

    logic                  grant_found;
    logic [IDW-1:0]        grant_idx;
    logic [NREQ*NBITS-1:0] a_shift, b_shift;

    // Round-robin pick: first requester at or after last_grant+1, wrapping.
    always_comb begin
        int unsigned     cand;
        logic [NREQ-1:0] req_shift;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        req_shift   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand      = (32'(last_grant_q) + k) % NREQ;
            req_shift = bus.req_valid >> cand;
            if (!grant_found && req_shift[0]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(cand);
            end
        end
        a_shift = bus.req_a >> (32'(grant_idx) * NBITS);
        b_shift = bus.req_b >> (32'(grant_idx) * NBITS);
    end

    // Next-state and registered-output values for the operation sequence.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        req_ready_d   = '0;
        resp_valid_d  = 1'b0;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_err_d    = resp_err_q;
        eng_a_d       = eng_a_q;
        eng_b_d       = eng_b_q;
        eng_start_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    owner_d     = grant_idx;
                    eng_a_d     = a_shift[NBITS-1:0];
                    eng_b_d     = b_shift[NBITS-1:0];
                    req_ready_d = NREQ'(1) << grant_idx;
                    state_d     = StGrant;
                end
            end
            StGrant: begin
                eng_start_d = 1'b1;
                state_d     = StStart;
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + CW'(1);
                // Done has priority over a watchdog expiry in the same cycle.
                if (bus.eng_done) begin
                    resp_result_d = bus.eng_result;
                    resp_err_d    = 1'b0;
                    resp_id_d     = owner_q;
                    resp_valid_d  = 1'b1;
                    state_d       = StResp;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    resp_result_d = '0;
                    resp_err_d    = 1'b1;
                    resp_id_d     = owner_q;
                    resp_valid_d  = 1'b1;
                    state_d       = StResp;
                end
            end
            StResp: begin
                last_grant_d = owner_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and output registers; async reset parks everything in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            last_grant_q  <= IDW'(NREQ - 1);
            owner_q       <= '0;
            cnt_q         <= '0;
            req_ready_q   <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_err_q    <= 1'b0;
            eng_a_q       <= '0;
            eng_b_q       <= '0;
            eng_start_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_err_q    <= resp_err_d;
            eng_a_q       <= eng_a_d;
            eng_b_q       <= eng_b_d;
            eng_start_q   <= eng_start_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.eng_a       = eng_a_q;
    assign bus.eng_b       = eng_b_q;
    assign bus.eng_start   = eng_start_q;
    assign bus.busy        = busy_q;
endmodule
